// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the FSM state enum and the count-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: max(1, clog2(w)).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// master = requester/consumer side, slave = the adder.
// Macro SERIAL_ADDER_SUB_EN adds the 1-bit sub request line.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  import serial_adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/behavioralFullAdder.sv
// One-bit full-adder cell shared by serial datapaths.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module behavioralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one FA cell, LSB first.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
// Macro SERIAL_ADDER_SUB_EN enables a-b via bus.sub.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] msb_ins;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_b, fa_s, fa_co;
  logic             req_sub;
  logic             hs;

`ifdef SERIAL_ADDER_SUB_EN
  assign req_sub = bus.sub;
`else
  assign req_sub = 1'b0;
`endif

  // Subtract feeds ~b; the +1 comes from the preset carry.
  assign fa_b = b_sh_q[0] ^ sub_q;

  behavioralFullAdder u_fa (
    .a    (a_sh_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign hs = (state_q == DONE) && out_valid_q && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    msb_ins  = '0;
    msb_ins[WIDTH-1] = fa_s;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          sub_d   = req_sub;
          carry_d = req_sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = (sum_sh_q >> 1) | msb_ins;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Valid is registered, so it rises one edge after DONE is entered.
    out_valid_d = (state_q == DONE) && !hs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Expected sums are queued on accept and popped on result.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   errs = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic mc,
                                       input logic ms);
    logic [W-1:0] nb;
    logic [W:0]   r;
    nb = ~mb;
    if (ms) r = {1'b0, ma} + {1'b0, nb} + 9'd1;
    else    r = {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic ts);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vec++;
    if (bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.a = ta;
    bus.b = tb_;
    bus.cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = ts;
`endif
    bus.in_valid = 1'b1;
    sb.push_back(model(ta, tb_, tc, ts));
    tick();
    bus.in_valid = 1'b0;
    vec++;
    if (bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL busy_after_accept: in_ready=%b required 0",
               bus.in_ready);
    end
  endtask

  // Waits for out_valid; checks edge count from the accept edge.
  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vec++;
    if (bus.out_valid !== 1'b1 || n != exp_lat) begin
      errs++;
      $display("FAIL latency: valid=%b after %0d edges required 1 after %0d",
               bus.out_valid, n, exp_lat);
    end
  endtask

  task automatic recv(input int hold);
    logic [W:0] got, exp;
    got = {bus.cout, bus.sum};
    for (int i = 0; i < hold; i++) begin
      tick();
      vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.cout, bus.sum} !== got) begin
        errs++;
        $display("FAIL backpressure_hold: v=%b rdy=%b res=%h required 1 0 %h",
                 bus.out_valid, bus.in_ready, {bus.cout, bus.sum}, got);
      end
    end
    vec++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_empty: result %h has no expected value",
               {bus.cout, bus.sum});
    end else begin
      exp = sb.pop_front();
      if ({bus.cout, bus.sum} !== exp) begin
        errs++;
        $display("FAIL result: cout,sum=%h required %h",
                 {bus.cout, bus.sum}, exp);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input int hold);
    send(ta, tb_, tc, ts);
    wait_valid(W + 1);
    recv(hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0) begin
      errs++;
      $display("FAIL reset: rdy=%b v=%b sum=%h cout=%b required 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b1, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_op(8'hA5, 8'h3C, 1'b1, 1'b0, 5);
  endtask

  task automatic test_run_noise();
    send(8'h5A, 8'h66, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.cin = 1'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
      vec++;
      if (bus.in_ready !== 1'b0) begin
        errs++;
        $display("FAIL run_in_ready: in_ready=%b required 0", bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    wait_valid(W + 1 - 4);
    recv(0);
  endtask

  task automatic test_reset_mid_run();
    send(8'h55, 8'hAA, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0) begin
      errs++;
      $display("FAIL mid_run_reset: rdy=%b v=%b sum=%h cout=%b required 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout);
    end
    sb.delete();
    rst_n = 1'b1;
    tick();
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
            int'($urandom_range(0, 2)));
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h80, 1'b0, 1'b1, 1);
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_run_noise();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
